// File: rtl/audio_mix_mac_if.sv
// Bus bundle for audio_mix_mac: mix-pass strobe, per-channel samples/gains/mutes, and mixed result/status.
interface audio_mix_mac_if #(
  parameter int CHANNELS = 4,
  parameter int IN_W     = 16,
  parameter int GAIN_W   = 12,
  parameter int OUT_W    = 16
);
  logic                       sample_ce;
  logic [CHANNELS*IN_W-1:0]   in_samples;
  logic [CHANNELS*GAIN_W-1:0] gains;
  logic [CHANNELS-1:0]        mute;
  logic [OUT_W-1:0]           out_sample;
  logic                       out_valid;
  logic                       busy;
  logic                       clip;
  logic                       overrun;
  logic [15:0]                clip_count;

  modport master (
    output sample_ce, in_samples, gains, mute,
    input  out_sample, out_valid, busy, clip, overrun, clip_count
  );

  modport slave (
    input  sample_ce, in_samples, gains, mute,
    output out_sample, out_valid, busy, clip, overrun, clip_count
  );
endinterface

// File: rtl/audio_mix_mac.sv
// Time-multiplexed N-channel audio mixer: one gain MAC per cycle, arithmetic shift, saturate to OUT_W.
// Optional saturation counter enabled by defining MIXER_CLIP_CNT_EN.
module audio_mix_mac #(
  parameter int CHANNELS  = 4,
  parameter int IN_W      = 16,
  parameter int GAIN_W    = 12,
  parameter int GAIN_FRAC = 7,
  parameter int OUT_W     = 16,
  parameter int ACC_W     = 32
) (
  input logic              clk_sys,
  input logic              reset,
  audio_mix_mac_if.slave   bus
);
  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PROD_W = IN_W + GAIN_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_SAT, ST_DONE} state_t;

  state_t                     r_state, w_next;
  logic                       w_start, w_busy, w_valid;
  logic [CHANNELS*IN_W-1:0]   r_smp;
  logic [CHANNELS*GAIN_W-1:0] r_gain;
  logic [CHANNELS-1:0]        r_mute;
  logic [IDX_W-1:0]           r_idx;
  logic signed [ACC_W-1:0]    r_acc;
  logic [OUT_W-1:0]           r_out;
  logic                       r_clip;
  logic                       r_overrun;
  logic signed [IN_W-1:0]     w_smp;
  logic [GAIN_W-1:0]          w_gain;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_term;
  logic signed [ACC_W-1:0]    w_shift;

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_busy  = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.sample_ce) begin
        w_next  = ST_MAC;
        w_start = 1'b1;
      end
      ST_MAC: begin
        w_busy = 1'b1;
        if (r_idx == LAST_IDX) w_next = ST_SAT;
      end
      ST_SAT: begin
        w_busy = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: begin
        w_valid = 1'b1;
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Gain is zero-extended by one bit so the multiply stays signed x signed.
  always_comb begin
    w_smp   = r_smp[r_idx*IN_W +: IN_W];
    w_gain  = r_gain[r_idx*GAIN_W +: GAIN_W];
    w_prod  = w_smp * $signed({1'b0, w_gain});
    w_term  = r_mute[r_idx] ? '0 : {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    w_shift = r_acc >>> GAIN_FRAC;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_smp     <= '0;
      r_gain    <= '0;
      r_mute    <= '0;
      r_idx     <= '0;
      r_acc     <= '0;
      r_out     <= '0;
      r_clip    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (bus.sample_ce && r_state != ST_IDLE) r_overrun <= 1'b1;
      if (w_start) begin
        r_smp  <= bus.in_samples;
        r_gain <= bus.gains;
        r_mute <= bus.mute;
        r_idx  <= '0;
        r_acc  <= '0;
      end
      if (r_state == ST_MAC) begin
        r_acc <= r_acc + w_term;
        r_idx <= r_idx + 1'b1;
      end
      if (r_state == ST_SAT) begin
        if (w_shift > MAX_V) begin
          r_out  <= {1'b0, {(OUT_W-1){1'b1}}};
          r_clip <= 1'b1;
        end else if (w_shift < MIN_V) begin
          r_out  <= {1'b1, {(OUT_W-1){1'b0}}};
          r_clip <= 1'b1;
        end else begin
          r_out  <= w_shift[OUT_W-1:0];
          r_clip <= 1'b0;
        end
      end
    end
  end

`ifdef MIXER_CLIP_CNT_EN
  logic [15:0] r_clip_cnt;
  always_ff @(posedge clk_sys) begin
    if (reset)
      r_clip_cnt <= '0;
    else if (r_state == ST_SAT && (w_shift > MAX_V || w_shift < MIN_V) && r_clip_cnt != '1)
      r_clip_cnt <= r_clip_cnt + 1'b1;
  end
  assign bus.clip_count = r_clip_cnt;
`else
  assign bus.clip_count = '0;
`endif

  assign bus.out_sample = r_out;
  assign bus.out_valid  = w_valid;
  assign bus.busy       = w_busy;
  assign bus.clip       = r_clip;
  assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_audio_mix_mac.sv
// Directed bench for audio_mix_mac (4 channels, default widths) with hand-computed expected results.
module tb_audio_mix_mac;
  localparam int CH = 4;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  int   lat;
  int   pulses;
  logic [15:0] exp_cc;

  audio_mix_mac_if #(.CHANNELS(CH), .IN_W(16), .GAIN_W(12), .OUT_W(16)) bus ();

  audio_mix_mac #(
    .CHANNELS(CH), .IN_W(16), .GAIN_W(12), .GAIN_FRAC(7), .OUT_W(16), .ACC_W(32)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus.master)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_ch();
    bus.in_samples = '0;
    bus.gains      = '0;
    bus.mute       = '0;
  endtask

  task automatic set_ch(input int k, input logic [15:0] s, input logic [11:0] g, input logic m);
    bus.in_samples[k*16 +: 16] = s;
    bus.gains[k*12 +: 12]      = g;
    bus.mute[k]                = m;
  endtask

  // Pulse sample_ce for one cycle, then count cycles until out_valid (bounded).
  task automatic run_pass(output int cycles);
    bus.sample_ce = 1'b1;
    tick();
    bus.sample_ce = 1'b0;
    cycles = 1;
    while (bus.out_valid !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    bus.sample_ce = 1'b0;
    clear_ch();
`ifdef MIXER_CLIP_CNT_EN
    exp_cc = 16'd2;
`else
    exp_cc = 16'd0;
`endif

    // 1: reset and idle
    tick(); tick();
    chk("rst_out_sample", 32'(bus.out_sample), 32'h0);
    chk("rst_out_valid",  32'(bus.out_valid),  32'h0);
    chk("rst_busy",       32'(bus.busy),       32'h0);
    chk("rst_clip",       32'(bus.clip),       32'h0);
    chk("rst_overrun",    32'(bus.overrun),    32'h0);
    chk("rst_clip_count", 32'(bus.clip_count), 32'h0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    chk("idle_quiet", 32'(pulses), 32'h0);

    // 2: unity gain on ch0, cycle-accurate busy/out_valid
    set_ch(0, 16'h1000, 12'd128, 1'b0);
    bus.sample_ce = 1'b1;
    tick();
    bus.sample_ce = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("busy_c%0d", c),  32'(bus.busy),      (c <= 5) ? 32'h1 : 32'h0);
      chk($sformatf("valid_c%0d", c), 32'(bus.out_valid), (c == 6) ? 32'h1 : 32'h0);
      if (c < 6) tick();
    end
    chk("unity_out",  32'(bus.out_sample), 32'h1000);
    chk("unity_clip", 32'(bus.clip),       32'h0);
    tick();
    chk("valid_one_cycle", 32'(bus.out_valid), 32'h0);
    chk("out_held",        32'(bus.out_sample), 32'h1000);

    // 3: positive and negative saturation
    clear_ch();
    set_ch(0, 16'h7000, 12'd128, 1'b0);
    set_ch(1, 16'h7000, 12'd128, 1'b0);
    run_pass(lat);
    chk("satp_lat",  32'(lat),             32'd6);
    chk("satp_out",  32'(bus.out_sample), 32'h7FFF);
    chk("satp_clip", 32'(bus.clip),       32'h1);
    tick();
    set_ch(0, 16'h9000, 12'd128, 1'b0);
    set_ch(1, 16'h9000, 12'd128, 1'b0);
    run_pass(lat);
    chk("satn_out",  32'(bus.out_sample), 32'h8000);
    chk("satn_clip", 32'(bus.clip),       32'h1);
    chk("satn_clip_count", 32'(bus.clip_count), 32'(exp_cc));
    tick();

    // 4: mute and 2x gain on a negative sample
    clear_ch();
    set_ch(0, 16'h1000, 12'd128, 1'b1);
    set_ch(1, 16'hF800, 12'd256, 1'b0);
    run_pass(lat);
    chk("mute_out",  32'(bus.out_sample), 32'hF000);
    chk("mute_clip", 32'(bus.clip),       32'h0);
    tick();

    // all channels muted
    clear_ch();
    for (int k = 0; k < CH; k++) set_ch(k, 16'h4000, 12'd200, 1'b1);
    run_pass(lat);
    chk("allmute_lat", 32'(lat),             32'd6);
    chk("allmute_out", 32'(bus.out_sample), 32'h0);
    tick();

    // max gain: 0x100*4095>>7 = 0x1FFE ; floor of -1*1>>7 = -1
    clear_ch();
    set_ch(0, 16'h0100, 12'hFFF, 1'b0);
    run_pass(lat);
    chk("maxgain_out", 32'(bus.out_sample), 32'h1FFE);
    tick();
    clear_ch();
    set_ch(2, 16'hFFFF, 12'd1, 1'b0);
    run_pass(lat);
    chk("floor_out",  32'(bus.out_sample), 32'hFFFF);
    chk("floor_clip", 32'(bus.clip),       32'h0);
    tick();

    // 5: sample_ce during a pass is ignored but flagged
    clear_ch();
    set_ch(0, 16'h0100, 12'd128, 1'b0);
    bus.sample_ce = 1'b1;
    tick();
    bus.sample_ce = 1'b0;
    tick(); tick();
    for (int k = 0; k < CH; k++) set_ch(k, 16'h7FFF, 12'd255, 1'b0);
    bus.sample_ce = 1'b1;
    tick();
    bus.sample_ce = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid === 1'b1) begin
        pulses++;
        chk("ovr_out", 32'(bus.out_sample), 32'h0100);
      end
      tick();
    end
    chk("ovr_single_valid", 32'(pulses),      32'd1);
    chk("ovr_flag",         32'(bus.overrun), 32'h1);
    clear_ch();
    set_ch(0, 16'h0100, 12'd128, 1'b0);
    run_pass(lat);
    chk("ovr_sticky", 32'(bus.overrun), 32'h1);
    tick();

    // 6: reset in the middle of a pass
    set_ch(0, 16'h0300, 12'd128, 1'b0);
    bus.sample_ce = 1'b1;
    tick();
    bus.sample_ce = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy",    32'(bus.busy),       32'h0);
    chk("midrst_out",     32'(bus.out_sample), 32'h0);
    chk("midrst_overrun", 32'(bus.overrun),    32'h0);
    chk("midrst_cc",      32'(bus.clip_count), 32'h0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid === 1'b1) pulses++;
      tick();
    end
    chk("midrst_no_valid", 32'(pulses), 32'h0);
    clear_ch();
    set_ch(0, 16'h0200, 12'd128, 1'b0);
    run_pass(lat);
    chk("post_rst_lat", 32'(lat),             32'd6);
    chk("post_rst_out", 32'(bus.out_sample), 32'h0200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
